// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the rectangle-drawing arbiter: FSM state encodings,
// default screen dimensions and a small index helper.
package vga_draw_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SCREEN_X_MAX = 160;
  localparam int SCREEN_Y_MAX = 120;

  // Next requester index after v, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_rr_arbiter.sv
// Combinational round-robin selector: the first asserted request found when
// scanning upward from ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  // Scan offsets 0..N-1 from ptr and take the first requester that is high.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (((int'(ptr) + k) % N) == j)) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Arbitrates several rectangle-fill requesters onto a single VGA adapter write
// port. The winner's rectangle is latched at grant time and drawn one pixel per
// cycle in raster order; off-screen pixels still take their cycle but are not
// plotted.
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int X_MAX   = SCREEN_X_MAX,
  parameter int Y_MAX   = SCREEN_Y_MAX
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*8-1:0]  rect_x,
  input  logic [NUM_REQ*7-1:0]  rect_y,
  input  logic [NUM_REQ*8-1:0]  rect_w,
  input  logic [NUM_REQ*7-1:0]  rect_h,
  input  logic [NUM_REQ*24-1:0] rect_color,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [7:0]            VGA_X,
  output logic [6:0]            VGA_Y,
  output logic [23:0]           VGA_COLOR,
  output logic                  plot
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [8:0] XLIM = 9'(X_MAX);
  localparam logic [7:0] YLIM = 8'(Y_MAX);

  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gidx_q, gidx_d;
  logic [7:0] x0_q, x0_d, w_q, w_d, cx_q, cx_d, vx_q, vx_d;
  logic [6:0] y0_q, y0_d, h_q, h_d, cy_q, cy_d, vy_q, vy_d;
  logic [23:0] col_q, col_d, vc_q, vc_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic busy_q, busy_d, plot_q, plot_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0] arb_idx;
  logic [7:0] win_x, win_w, bx;
  logic [6:0] win_y, win_h, by;
  logic [23:0] win_c, bc;
  logic [8:0] sx;
  logic [7:0] sy;
  logic emit;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Pick out the rectangle parameters belonging to the arbitration winner.
  always_comb begin
    win_x = '0;
    win_y = '0;
    win_w = '0;
    win_h = '0;
    win_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        win_x = rect_x[8*i +: 8];
        win_y = rect_y[7*i +: 7];
        win_w = rect_w[8*i +: 8];
        win_h = rect_h[7*i +: 7];
        win_c = rect_color[24*i +: 24];
      end
    end
  end

  // FSM next state plus the registered pixel for the upcoming cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    done_d  = '0;
    busy_d  = 1'b0;
    plot_d  = 1'b0;
    emit    = 1'b0;
    bx      = x0_q;
    by      = y0_q;
    bc      = col_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gidx_d = arb_idx;
          x0_d   = win_x;
          y0_d   = win_y;
          w_d    = win_w;
          h_d    = win_h;
          col_d  = win_c;
          cx_d   = '0;
          cy_d   = '0;
          busy_d = 1'b1;
          if (win_w == 8'd0 || win_h == 7'd0) begin
            state_d = ST_DONE;
            done_d  = arb_grant;
          end else begin
            state_d = ST_DRAW;
            emit    = 1'b1;
            bx      = win_x;
            by      = win_y;
            bc      = win_c;
          end
        end
      end
      ST_DRAW: begin
        busy_d = 1'b1;
        if (cx_q == w_q - 8'd1) begin
          cx_d = '0;
          if (cy_q == h_q - 7'd1) begin
            state_d = ST_DONE;
            for (int i = 0; i < NUM_REQ; i++) begin
              done_d[i] = (gidx_q == IW'(i));
            end
          end else begin
            cy_d = cy_q + 7'd1;
            emit = 1'b1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
          emit = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = IW'(wrap_inc(int'(gidx_q), NUM_REQ));
      end
      default: state_d = ST_IDLE;
    endcase
    sx = {1'b0, bx} + {1'b0, cx_d};
    sy = {1'b0, by} + {1'b0, cy_d};
    if (emit && (sx < XLIM) && (sy < YLIM)) begin
      plot_d = 1'b1;
      vx_d   = sx[7:0];
      vy_d   = sy[6:0];
      vc_d   = bc;
    end
  end

  // State and output registers; reset abandons any rectangle in progress.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      plot_q  <= plot_d;
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign plot      = plot_q;
  assign VGA_X     = vx_q;
  assign VGA_Y     = vy_q;
  assign VGA_COLOR = vc_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: a table of single-requester rectangles
// checked pixel by pixel, then round-robin and mid-draw reset sequences.
module tb_vga_draw_arbiter;

  localparam int N = 3;

  logic          CLOCK_50 = 1'b0;
  logic          resetn;
  logic [N-1:0]  req;
  logic [N*8-1:0]  rect_x;
  logic [N*7-1:0]  rect_y;
  logic [N*8-1:0]  rect_w;
  logic [N*7-1:0]  rect_h;
  logic [N*24-1:0] rect_color;
  logic [N-1:0]  done;
  logic          busy;
  logic [7:0]    VGA_X;
  logic [6:0]    VGA_Y;
  logic [23:0]   VGA_COLOR;
  logic          plot;

  int errors = 0;
  int checks = 0;

  logic [7:0]  lastX = '0;
  logic [6:0]  lastY = '0;
  logic [23:0] lastC = '0;

  typedef struct {
    int          r;
    int          x;
    int          y;
    int          w;
    int          h;
    logic [23:0] col;
    bit          chg;
    int          expPlots;
  } vec_t;

  vec_t vecs[8];

  vga_draw_arbiter #(.NUM_REQ(N), .X_MAX(160), .Y_MAX(120)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .req        (req),
    .rect_x     (rect_x),
    .rect_y     (rect_y),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .rect_color (rect_color),
    .done       (done),
    .busy       (busy),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .VGA_COLOR  (VGA_COLOR),
    .plot       (plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_plot"}, 32'(plot), 0);
    checkOutput({tag, "_x"}, 32'(VGA_X), 0);
    checkOutput({tag, "_y"}, 32'(VGA_Y), 0);
    checkOutput({tag, "_color"}, 32'(VGA_COLOR), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    rect_x[8*v.r +: 8]      = 8'(v.x);
    rect_y[7*v.r +: 7]      = 7'(v.y);
    rect_w[8*v.r +: 8]      = 8'(v.w);
    rect_h[7*v.r +: 7]      = 7'(v.h);
    rect_color[24*v.r +: 24] = v.col;
    req = '0;
    req[v.r] = 1'b1;
  endtask

  task automatic runVector(input int id, input vec_t v);
    int n;
    int ex;
    int ey;
    int dutPlots;
    bit inb;
    n = v.w * v.h;
    dutPlots = 0;
    applyStimulus(v);
    for (int c = 0; c < n; c++) begin
      @(negedge CLOCK_50);
      ex = v.x + (c % v.w);
      ey = v.y + (c / v.w);
      inb = (ex < 160) && (ey < 120);
      if (inb) begin
        lastX = 8'(ex);
        lastY = 7'(ey);
        lastC = v.col;
      end
      if (plot) dutPlots++;
      checkOutput($sformatf("v%0d_plot_c%0d", id, c), 32'(plot), 32'(inb));
      checkOutput($sformatf("v%0d_busy_c%0d", id, c), 32'(busy), 1);
      checkOutput($sformatf("v%0d_nodone_c%0d", id, c), 32'(done), 0);
      checkOutput($sformatf("v%0d_x_c%0d", id, c), 32'(VGA_X), 32'(lastX));
      checkOutput($sformatf("v%0d_y_c%0d", id, c), 32'(VGA_Y), 32'(lastY));
      checkOutput($sformatf("v%0d_col_c%0d", id, c), 32'(VGA_COLOR), 32'(lastC));
      if (v.chg && c == 0) rect_color[24*v.r +: 24] = ~v.col;
    end
    @(negedge CLOCK_50);
    checkOutput($sformatf("v%0d_done", id), 32'(done), 32'(1) << v.r);
    checkOutput($sformatf("v%0d_done_busy", id), 32'(busy), 1);
    checkOutput($sformatf("v%0d_done_plot", id), 32'(plot), 0);
    checkOutput($sformatf("v%0d_done_xhold", id), 32'(VGA_X), 32'(lastX));
    req = '0;
    @(negedge CLOCK_50);
    checkOutput($sformatf("v%0d_idle_done", id), 32'(done), 0);
    checkOutput($sformatf("v%0d_idle_busy", id), 32'(busy), 0);
    checkOutput($sformatf("v%0d_idle_plot", id), 32'(plot), 0);
    checkOutput($sformatf("v%0d_plot_count", id), 32'(dutPlots), 32'(v.expPlots));
  endtask

  initial begin
    int expOrder[6];
    int ndone;
    int nplot;

    vecs[0] = '{0, 10, 20, 2, 2, 24'hFF0000, 1'b0, 4};
    vecs[1] = '{1, 158, 119, 4, 2, 24'h00FF00, 1'b0, 2};
    vecs[2] = '{2, 5, 5, 0, 5, 24'h777777, 1'b0, 0};
    vecs[3] = '{0, 0, 0, 3, 1, 24'h0000FF, 1'b1, 3};
    vecs[4] = '{2, 100, 50, 1, 3, 24'h123456, 1'b0, 3};
    vecs[5] = '{1, 159, 118, 2, 3, 24'hABCDEF, 1'b0, 2};
    vecs[6] = '{0, 255, 127, 2, 1, 24'h0F0F0F, 1'b0, 0};
    vecs[7] = '{1, 40, 40, 3, 0, 24'h333333, 1'b0, 0};

    resetn = 1'b0;
    req = '0;
    rect_x = '0;
    rect_y = '0;
    rect_w = '0;
    rect_h = '0;
    rect_color = '0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checkAllZero("reset");
    resetn = 1'b1;
    @(negedge CLOCK_50);
    checkAllZero("post_reset");

    for (int i = 0; i < 8; i++) runVector(i, vecs[i]);

    // Round robin with all three requesters held high.
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    for (int i = 0; i < N; i++) begin
      rect_x[8*i +: 8] = 8'(30 + 10 * i);
      rect_y[7*i +: 7] = 7'd10;
      rect_w[8*i +: 8] = 8'd1;
      rect_h[7*i +: 7] = 7'd1;
      rect_color[24*i +: 24] = 24'(i + 1);
    end
    expOrder = '{0, 1, 2, 0, 1, 2};
    ndone = 0;
    nplot = 0;
    req = 3'b111;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLOCK_50);
      if (plot) begin
        if (nplot < 6) checkOutput($sformatf("rr_x_%0d", nplot), 32'(VGA_X), 32'(30 + 10 * expOrder[nplot]));
        nplot++;
      end
      if (done != '0) begin
        if (ndone < 6) checkOutput($sformatf("rr_done_%0d", ndone), 32'(done), 32'(1) << expOrder[ndone]);
        ndone++;
      end
    end
    checkOutput("rr_done_count", 32'(ndone), 6);
    checkOutput("rr_plot_count", 32'(nplot), 6);
    req = '0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);

    // Reset during the third pixel of a 4x4 rectangle.
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    rect_x[7:0] = 8'd20;
    rect_y[6:0] = 7'd30;
    rect_w[7:0] = 8'd4;
    rect_h[6:0] = 7'd4;
    rect_color[23:0] = 24'hAABBCC;
    req = 3'b001;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("rst_pre_x", 32'(VGA_X), 22);
    resetn = 1'b0;
    #1;
    checkAllZero("midreset");
    req = 3'b000;
    @(negedge CLOCK_50);
    checkOutput("midreset_nodone", 32'(done), 0);
    rect_x[15:8] = 8'd70;
    rect_y[13:7] = 7'd5;
    rect_w[15:8] = 8'd1;
    rect_h[13:7] = 7'd1;
    rect_x[23:16] = 8'd90;
    rect_y[20:14] = 7'd5;
    rect_w[23:16] = 8'd1;
    rect_h[20:14] = 7'd1;
    req = 3'b110;
    resetn = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("rst_first_plot", 32'(plot), 1);
    checkOutput("rst_first_x", 32'(VGA_X), 70);
    @(negedge CLOCK_50);
    checkOutput("rst_first_done", 32'(done), 32'b010);
    req = '0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("final_idle_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
